// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 select datapath between four requesters.
// Grant tenure is bounded to MAX_HOLD cycles whenever another requester waits.
module mux_rr_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       gnt,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [3:0]    others;
    logic [1:0]    idle_pick;
    logic [1:0]    next_owner;

    // First requester at or after 'from' in circular order.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] from);
        logic [1:0] k;
        logic [1:0] res;
        res = from;
        for (int j = 3; j >= 0; j--) begin
            k = from + 2'(j);
            if (r[k]) res = k;
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gnt_d      = gnt_q;
        others     = req & ~(4'b0001 << sel_q);
        idle_pick  = pick(req, ptr_q);
        next_owner = pick(others, sel_q + 2'd1);
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                    sel_d   = idle_pick;
                    gnt_d   = 4'b0001 << idle_pick;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                // Release wins over expiry when both happen on the same edge.
                if (!req[sel_q] || ((|others) && hold_q == HOLD_LAST)) begin
                    ptr_d  = sel_q + 2'd1;
                    hold_d = '0;
                    if (|others) begin
                        sel_d = next_owner;
                        gnt_d = 4'b0001 << next_owner;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = (state_q == StGrant);

    always_comb begin
        y = '0;
        if (busy) begin
            unique case (sel_q)
                2'd0: y = i0;
                2'd1: y = i1;
                2'd2: y = i2;
                2'd3: y = i3;
                default: y = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario bench for mux_rr_arbiter: expected grant/select/data per cycle are
// queued as stimulus is applied and compared after the following clock edge.
module tb_mux_rr_arbiter;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic [7:0] y;
    } obs_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req   = 4'b0000;
    logic [WIDTH-1:0] dat [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    logic [WIDTH-1:0] i0, i1, i2, i3, y;
    logic [3:0]       gnt;
    logic             s1, s0, busy;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    assign i0 = dat[0];
    assign i1 = dat[1];
    assign i2 = dat[2];
    assign i3 = dat[3];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .i0   (i0),
        .i1   (i1),
        .i2   (i2),
        .i3   (i3),
        .gnt  (gnt),
        .s1   (s1),
        .s0   (s0),
        .y    (y),
        .busy (busy)
    );

    function automatic obs_t observe();
        obs_t o;
        o.gnt  = gnt;
        o.sel  = {s1, s0};
        o.busy = busy;
        o.y    = y;
        return o;
    endfunction

    function automatic obs_t grant_of(int k);
        obs_t e;
        e.gnt  = 4'b0001 << k;
        e.sel  = 2'(k);
        e.busy = 1'b1;
        e.y    = dat[k];
        return e;
    endfunction

    function automatic obs_t idle_of(logic [1:0] s);
        obs_t e;
        e.gnt  = 4'b0000;
        e.sel  = s;
        e.busy = 1'b0;
        e.y    = 8'h00;
        return e;
    endfunction

    task automatic tick(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e, got;
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        exp_q.push_back(idle_of(2'd0));
        got = observe();
        e   = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", got, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // One idle cycle, then requester 2 alone.
        exp_q.push_back(idle_of(2'd0));
        tick(4'b0000);
        got = observe();
        e   = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL reset_idle: got %h want %h", got, e);
        end
        exp_q.push_back(grant_of(2));
        tick(4'b0100);
        got = observe();
        e   = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL first_grant: got %h want %h", got, e);
        end
    endtask

    task automatic test_rotation();
        obs_t e, got;
        do_reset();
        for (int t = 0; t < 20; t++) begin
            exp_q.push_back(grant_of((t / 4) % 4));
            tick(4'b1111);
            got = observe();
            e   = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL rotation cycle %0d: got %h want %h", t, got, e);
            end
        end
    endtask

    task automatic test_saturated_expiry();
        obs_t e, got;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            exp_q.push_back(grant_of(1));
            tick(4'b0010);
            got = observe();
            e   = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL sole_owner cycle %0d: got %h want %h", t, got, e);
            end
        end
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back(grant_of(3));
            tick(4'b1010);
            got = observe();
            e   = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL sat_expiry cycle %0d: got %h want %h", t, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, got;
        logic [3:0] rq [3] = '{4'b0100, 4'b0101, 4'b0001};
        int         own[3] = '{2, 2, 0};
        do_reset();
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back(grant_of(own[t]));
            tick(rq[t]);
            got = observe();
            e   = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", t, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, got;
        do_reset();
        for (int t = 0; t < 2; t++) begin
            exp_q.push_back(grant_of(3));
            tick(4'b1000);
            got = observe();
            e   = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL owner3 cycle %0d: got %h want %h", t, got, e);
            end
        end
        // Drop reset between clock edges; outputs must clear without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(idle_of(2'd0));
        got = observe();
        e   = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL async_clear: got %h want %h", got, e);
        end
        @(negedge clk);
        req   = 4'b1001;
        rst_n = 1'b1;
        exp_q.push_back(grant_of(0));
        @(posedge clk);
        #1;
        got = observe();
        e   = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL post_reset_pick: got %h want %h", got, e);
        end
    endtask

    task automatic test_release_idle();
        obs_t e, got;
        obs_t exps[3];
        logic [3:0] rq [3] = '{4'b0010, 4'b0000, 4'b0011};
        exps[0] = grant_of(1);
        exps[1] = idle_of(2'd1);
        exps[2] = grant_of(0);
        do_reset();
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back(exps[t]);
            tick(rq[t]);
            got = observe();
            e   = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL release_idle cycle %0d: got %h want %h", t, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_saturated_expiry();
        test_back_to_back();
        test_async_reset();
        test_release_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
